// File: rtl/i2c_arb_pkg.sv
// Shared types for the two-port I2C write-request arbiter.
// FSM state encoding, grant policy constants and the port selector.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic POL_FIXED = 1'b0;
  localparam logic POL_RR    = 1'b1;

  localparam int TMR_W = 16;

  // A lone request always wins; a tie goes to the port not served
  // last under round-robin, or to port 0 under fixed priority.
  function automatic logic pick_port(
    input logic r0,
    input logic r1,
    input logic last,
    input logic policy
  );
    if (r0 && r1) begin
      return (policy == POL_RR) ? ~last : 1'b0;
    end
    return r1;
  endfunction

endpackage

// File: rtl/i2c_arb_timer.sv
// Saturating WAIT-state watchdog for the I2C request arbiter.
// Counts while enabled; expire flags the final allowed cycle.
module i2c_arb_timer
  import i2c_arb_pkg::*;
#(
  parameter logic [TMR_W-1:0] LIMIT = 16'd50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST =
    (LIMIT == '0) ? '0 : LIMIT - 1'b1;

  logic [TMR_W-1:0] count;

  // Cycle counter: clear wins, then count up and hold at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count >= LAST);

endmodule

// File: rtl/i2c_req_arbiter.sv
// Two-port arbiter in front of a single i2c_dri write engine.
// Port 0 is the boot sequencer, port 1 the runtime controller.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter logic [TMR_W-1:0] TIMEOUT_CYC = 16'd50_000,
  parameter logic             RR_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       done0,
  output logic       err0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       done1,
  output logic       err1,
  output logic       i2c_exec,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data_w,
  input  logic       i2c_done,
  output logic       busy,
  output logic       owner
);

  arb_state_t state;
  arb_state_t state_nx;

  logic any_req;
  logic grant;
  logic last_grant;
  logic stat_err;
  logic tmr_clear;
  logic tmr_en;
  logic expire;
  logic finish;

  assign any_req = req0 | req1;
  assign grant   = pick_port(req0, req1, last_grant, RR_EN);
  assign finish  = i2c_done | expire;

  i2c_arb_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: one trigger cycle, then wait for done or timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (any_req) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (finish) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
    endcase
  end

  // Moore outputs, so reset clears them the moment state does.
  always_comb begin
    i2c_exec  = (state == ST_ISSUE);
    busy      = (state != ST_IDLE);
    tmr_en    = (state == ST_WAIT);
    tmr_clear = (state != ST_WAIT);
    done0     = (state == ST_DONE) && !owner;
    done1     = (state == ST_DONE) &&  owner;
    err0      = done0 && stat_err;
    err1      = done1 && stat_err;
  end

  // Grant capture: owner and payload frozen until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      i2c_addr   <= 8'h00;
      i2c_data_w <= 8'h00;
    end else if ((state == ST_IDLE) && any_req) begin
      owner      <= grant;
      i2c_addr   <= grant ? addr1  : addr0;
      i2c_data_w <= grant ? wdata1 : wdata0;
    end
  end

  // Completion status (done beats timeout) and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_err   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if ((state == ST_WAIT) && finish) begin
        stat_err <= !i2c_done;
      end
      if (state == ST_DONE) begin
        last_grant <= owner;
      end
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: round-robin and fixed
// instances run in lockstep against one i2c_dri response model.
module tb_i2c_req_arbiter;

  typedef struct {
    logic       port;
    logic       fport;
    logic [7:0] addr;
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] addr0 = 8'h00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] addr1 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic       i2c_done = 1'b0;

  logic       done0, err0, done1, err1;
  logic       i2c_exec, busy, owner;
  logic [7:0] i2c_addr, i2c_data_w;

  logic       fx_done0, fx_err0, fx_done1, fx_err1;
  logic       fx_exec, fx_busy, fx_owner;
  logic [7:0] fx_addr, fx_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exec_cyc = 0;
  int   dri_delay = 20;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  i2c_req_arbiter #(
    .TIMEOUT_CYC (16'd100),
    .RR_EN       (1'b1)
  ) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .done0      (done0),
    .err0       (err0),
    .req1       (req1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .done1      (done1),
    .err1       (err1),
    .i2c_exec   (i2c_exec),
    .i2c_addr   (i2c_addr),
    .i2c_data_w (i2c_data_w),
    .i2c_done   (i2c_done),
    .busy       (busy),
    .owner      (owner)
  );

  i2c_req_arbiter #(
    .TIMEOUT_CYC (16'd100),
    .RR_EN       (1'b0)
  ) u_fx (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .done0      (fx_done0),
    .err0       (fx_err0),
    .req1       (req1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .done1      (fx_done1),
    .err1       (fx_err1),
    .i2c_exec   (fx_exec),
    .i2c_addr   (fx_addr),
    .i2c_data_w (fx_data),
    .i2c_done   (i2c_done),
    .busy       (fx_busy),
    .owner      (fx_owner)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // i2c_dri model: one-cycle done, dri_delay cycles after exec.
  // A delay of 0 means the engine never answers.
  int  rem = 0;
  bit  pend = 1'b0;
  always @(negedge clk) begin
    i2c_done = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (rem == 1) begin
          i2c_done = 1'b1;
          pend = 1'b0;
        end else begin
          rem--;
        end
      end
      if (i2c_exec && dri_delay != 0) begin
        pend = 1'b1;
        rem = dri_delay;
      end
    end
  end

  // Monitor: grant contents at exec, completion at done.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (i2c_exec) begin
        exec_cyc = cyc;
        chk("exec_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb[0];
          chk("owner", owner, e.port);
          chk("i2c_addr", i2c_addr, e.addr);
          chk("i2c_data_w", i2c_data_w, e.data);
          chk("fx_exec", fx_exec, 1);
          chk("fx_owner", fx_owner, e.fport);
        end
      end
      if (done0 | done1) begin
        chk("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_onehot", done0 ^ done1, 1);
          chk("done_port", done1, e.port);
          chk("err", err0 | err1, e.err);
          chk("err_port", err1, e.err & e.port);
          chk("done_lat", cyc - exec_cyc, e.lat);
          chk("addr_hold", i2c_addr, e.addr);
          chk("data_hold", i2c_data_w, e.data);
          chk("fx_done_port", fx_done1, e.fport);
          chk("fx_done", fx_done0 | fx_done1, 1);
          chk("fx_err", fx_err0 | fx_err1, e.err);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // One request; req drops and payload scrambles right after exec.
  task automatic single(input logic p, input logic [7:0] a,
                        input logic [7:0] d, input int dly,
                        input logic e, input int lat);
    exp_t x;
    dri_delay = dly;
    x = '{port: p, fport: p, addr: a, data: d, err: e, lat: lat};
    sb.push_back(x);
    @(negedge clk);
    if (p) begin
      req1 = 1'b1; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; addr0 = a; wdata0 = d;
    end
    @(negedge clk);
    chk("exec_lat", i2c_exec, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    addr0 = ~a; wdata0 = ~d;
    addr1 = ~a; wdata1 = ~d;
    drain();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_exec"}, i2c_exec, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_addr"}, i2c_addr, 8'h00);
    chk({tag, "_data"}, i2c_data_w, 8'h00);
    chk({tag, "_done"}, {done0, done1, err0, err1}, 4'h0);
    chk({tag, "_fx_busy"}, fx_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    int   n;
    #1;
    chk_reset_vals("rst0");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous requests held: RR alternates, fixed stays on 0.
    dri_delay = 20;
    for (int i = 0; i < 4; i++) begin
      x.port  = i[0];
      x.fport = 1'b0;
      x.addr  = i[0] ? 8'hA1 : 8'hA0;
      x.data  = i[0] ? 8'h1A : 8'h0A;
      x.err   = 1'b0;
      x.lat   = 21;
      sb.push_back(x);
    end
    @(negedge clk);
    addr0 = 8'hA0; wdata0 = 8'h0A;
    addr1 = 8'hA1; wdata1 = 8'h1A;
    req0 = 1'b1;
    req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 500 && n < 4; i++) begin
      @(negedge clk);
      if (i2c_exec) n++;
    end
    chk("rr_execs", n, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    // Plain write, then a second with payload changed during WAIT.
    single(1'b0, 8'h02, 8'hB3, 20, 1'b0, 21);
    single(1'b0, 8'h10, 8'h20, 20, 1'b0, 21);

    // No answer: timeout, then normal service resumes.
    single(1'b1, 8'h33, 8'h44, 0, 1'b1, 101);
    single(1'b1, 8'h35, 8'h46, 20, 1'b0, 21);

    // Answer lands on the timeout cycle: done wins.
    single(1'b0, 8'h5A, 8'hA5, 100, 1'b0, 101);

    // Reset mid-WAIT abandons the write silently.
    dri_delay = 20;
    x = '{port: 1'b1, fport: 1'b1, addr: 8'h55, data: 8'h66,
          err: 1'b0, lat: 21};
    sb.push_back(x);
    @(negedge clk);
    req1 = 1'b1; addr1 = 8'h55; wdata1 = 8'h66;
    @(negedge clk);
    chk("rst_exec", i2c_exec, 1);
    req1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy_pre", busy, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rstw");
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_idle", busy, 0);

    // Port 1 served from IDLE after reset.
    single(1'b1, 8'h77, 8'h88, 20, 1'b0, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
